// File: rtl/mem_bus_pkg.sv
// Shared definitions for the multiplexed-address external memory bus controller.
package mem_bus_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned WAIT_MAX_DEF   = 15;
  localparam int unsigned WAIT_CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_ACCESS,
    ST_DONE
  } bus_state_e;

endpackage

// File: rtl/mem_bus_interface_if.sv
// Controller request/response handshake plus the external multiplexed memory bus.
interface mem_bus_interface_if
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  reqValid;
  logic                  reqWrite;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [DATA_WIDTH-1:0] reqWData;
  logic                  reqReady;
  logic                  busy;
  logic                  rspValid;
  logic [DATA_WIDTH-1:0] rspRData;
  logic                  rspErr;
  logic [DATA_WIDTH-1:0] busOut;
  logic [DATA_WIDTH-1:0] busIn;
  logic                  busOe;
  logic                  aleHi;
  logic                  aleLo;
  logic                  weN;
  logic                  oeN;
  logic                  memRdy;

  modport master (
    output reqValid, reqWrite, reqAddr, reqWData, busIn, memRdy,
    input  reqReady, busy, rspValid, rspRData, rspErr,
           busOut, busOe, aleHi, aleLo, weN, oeN
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqWData, busIn, memRdy,
    output reqReady, busy, rspValid, rspRData, rspErr,
           busOut, busOe, aleHi, aleLo, weN, oeN
  );

endinterface

// File: rtl/mem_bus_interface_wait_counter.sv
// 8-bit clear/increment counter; tc_o flags that the current cycle is the LIMIT-th.
module WaitCounter
  import mem_bus_pkg::*;
#(
  parameter int unsigned LIMIT = WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [WAIT_CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + WAIT_CNT_W'(1);
    end
  end

  // Count holds completed wait cycles, so LIMIT-1 means this is the last allowed one.
  assign tc_o = (count_q == WAIT_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_interface.sv
// Turns single controller requests into ADDR_HI/ADDR_LO/ACCESS/DONE cycles on a
// multiplexed 8-bit memory bus, with a wait-state timeout.
module mem_bus_interface
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned WAIT_MAX   = WAIT_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_interface_if.slave   bus
);

  bus_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  wait_clr, wait_inc, wait_tc;

  logic                  ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] bus_out;
  logic                  bus_oe, ale_hi, ale_lo, we_n, oe_n;

  WaitCounter #(.LIMIT(WAIT_MAX)) u_wait (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (wait_clr),
    .inc_i (wait_inc),
    .tc_o  (wait_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    wait_clr = 1'b0;
    wait_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.reqValid) begin
          state_d = ST_ADDR_HI;
          addr_d  = bus.reqAddr;
          wdata_d = bus.reqWData;
          write_d = bus.reqWrite;
        end
      end
      ST_ADDR_HI: state_d = ST_ADDR_LO;
      ST_ADDR_LO: begin
        state_d  = ST_ACCESS;
        wait_clr = 1'b1;
      end
      ST_ACCESS: begin
        // memRdy is tested first so a ready on the final wait cycle still succeeds.
        if (bus.memRdy) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          rdata_d = write_q ? '0 : bus.busIn;
        end else if (wait_tc) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    rsp_valid = 1'b0;
    bus_out   = '0;
    bus_oe    = 1'b0;
    ale_hi    = 1'b0;
    ale_lo    = 1'b0;
    we_n      = 1'b1;
    oe_n      = 1'b1;
    unique case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_ADDR_HI: begin
        bus_oe  = 1'b1;
        bus_out = DATA_WIDTH'(addr_q >> DATA_WIDTH);
        ale_hi  = 1'b1;
      end
      ST_ADDR_LO: begin
        bus_oe  = 1'b1;
        bus_out = DATA_WIDTH'(addr_q);
        ale_lo  = 1'b1;
      end
      ST_ACCESS: begin
        if (write_q) begin
          bus_oe  = 1'b1;
          bus_out = wdata_q;
          we_n    = 1'b0;
        end else begin
          oe_n    = 1'b0;
        end
      end
      ST_DONE: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.reqReady = ready;
  assign bus.busy     = ~ready;
  assign bus.rspValid = rsp_valid;
  assign bus.rspRData = rdata_q;
  assign bus.rspErr   = err_q;
  assign bus.busOut   = bus_out;
  assign bus.busOe    = bus_oe;
  assign bus.aleHi    = ale_hi;
  assign bus.aleLo    = ale_lo;
  assign bus.weN      = we_n;
  assign bus.oeN      = oe_n;

endmodule
